sha_round_sequencer: RTL and testbench

Parametrised control sequencer for the multi-pass SHA hashing datapath of the miner.
- Steps the datapath through prep, round, write and verify phases for PASSES back-to-back compressions (default double SHA-256).
- Drives the read, round-function-select, IV-load, digest-capture and verify strobes.
- Handshakes with the host through start/busy/done and reports the nonce under test.
- Replaces the fixed 64-round free-running controller with a start-triggered, abortable, configurable one.

---
 rtl/sha_ctrl_pkg.sv | 23 ++
 rtl/hash_round_counter.sv | 45 ++++
 rtl/sha_round_sequencer.sv | 163 ++++++++++++++++
 tb/tb_sha_round_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha_ctrl_pkg.sv
// Shared types and constants for the SHA round sequencer: FSM state encoding,
// SHA-256 default geometry and the width helper used for derived port widths.
package sha_ctrl_pkg;

  localparam int unsigned SHA256_ROUNDS       = 64;
  localparam int unsigned SHA256_SCHED_DIRECT = 16;
  localparam int unsigned SHA256_PASSES       = 2;
  localparam int unsigned SHA256_FUNC_GROUPS  = 1;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    HASH,
    WRITE,
    VERIFY
  } seq_state_t;

  // Counter/select width that never collapses to zero bits for a count of 1.
  function automatic int unsigned min1_clog2(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hash_round_counter.sv
// Round counter for the HASH phase: synchronous clear, count enable, wrap at
// ROUNDS-1 with a terminal-count flag, and the round-function group index.
module hash_round_counter
  import sha_ctrl_pkg::*;
#(
  parameter int unsigned ROUNDS      = SHA256_ROUNDS,
  parameter int unsigned FUNC_GROUPS = 4,
  parameter int unsigned ROUND_W     = $clog2(ROUNDS),
  parameter int unsigned FUNC_W      = min1_clog2(FUNC_GROUPS)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clr,
  input  logic               en,
  output logic [ROUND_W-1:0] round,
  output logic               last,
  output logic [FUNC_W-1:0]  group
);

  localparam int unsigned GROUP_SIZE = ROUNDS / FUNC_GROUPS;

  logic [ROUND_W-1:0] round_q, round_d;

  assign last  = (round_q == ROUND_W'(ROUNDS - 1));
  assign round = round_q;
  assign group = FUNC_W'(32'(round_q) / GROUP_SIZE);

  always_comb begin
    round_d = round_q;
    if (clr) begin
      round_d = '0;
    end else if (en) begin
      round_d = last ? '0 : round_q + ROUND_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      round_q <= '0;
    end else begin
      round_q <= round_d;
    end
  end

endmodule

// File: rtl/sha_round_sequencer.sv
// Start-triggered, abortable control sequencer for the multi-pass SHA datapath.
// Optional NONCE_SWEEP_EN: VERIFY steps the nonce up to nonce_last until a hit.
module sha_round_sequencer
  import sha_ctrl_pkg::*;
#(
  parameter int unsigned ROUNDS       = SHA256_ROUNDS,
  parameter int unsigned PASSES       = SHA256_PASSES,
  parameter int unsigned FUNC_GROUPS  = 4,
  parameter int unsigned SCHED_DIRECT = SHA256_SCHED_DIRECT,
  parameter int unsigned NONCE_W      = 32
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                start,
  input  logic                                abort,
  input  logic [NONCE_W-1:0]                  nonce_start,
  input  logic [NONCE_W-1:0]                  nonce_last,
  input  logic                                hit,
  output logic                                busy,
  output logic                                done,
  output logic                                found,
  output logic [NONCE_W-1:0]                  nonce,
  output logic                                c_init,
  output logic                                c_read,
  output logic [min1_clog2(FUNC_GROUPS)-1:0]  c_func,
  output logic [$clog2(ROUNDS)-1:0]           c_round,
  output logic [min1_clog2(PASSES)-1:0]       c_pass,
  output logic                                c_write,
  output logic                                c_verify
);

  localparam int unsigned RW = $clog2(ROUNDS);
  localparam int unsigned FW = min1_clog2(FUNC_GROUPS);
  localparam int unsigned PW = min1_clog2(PASSES);

  seq_state_t         state_q, state_d;
  logic [PW-1:0]      pass_q, pass_d;
  logic [NONCE_W-1:0] nonce_q, nonce_d;
  logic               found_q, found_d;
  logic               done_q, done_d;
  logic               cnt_clr, cnt_en, cnt_last;
  logic [RW-1:0]      round;
  logic [FW-1:0]      group;

`ifdef NONCE_SWEEP_EN
  logic [NONCE_W-1:0] nonce_last_q, nonce_last_d;
`else
  logic unused_nonce_last;
  assign unused_nonce_last = ^nonce_last;
`endif

  hash_round_counter #(
    .ROUNDS      (ROUNDS),
    .FUNC_GROUPS (FUNC_GROUPS),
    .ROUND_W     (RW),
    .FUNC_W      (FW)
  ) u_round_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .round   (round),
    .last    (cnt_last),
    .group   (group)
  );

  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    nonce_d = nonce_q;
    found_d = found_q;
    done_d  = 1'b0;
    cnt_clr = 1'b1;
    cnt_en  = 1'b0;
`ifdef NONCE_SWEEP_EN
    nonce_last_d = nonce_last_q;
`endif
    if (state_q == IDLE) begin
      if (start && !abort) begin
        nonce_d = nonce_start;
`ifdef NONCE_SWEEP_EN
        nonce_last_d = nonce_last;
`endif
        found_d = 1'b0;
        pass_d  = '0;
        state_d = PREP;
      end
    end else if (abort) begin
      // Abort wins over every phase, including the VERIFY that would pulse done.
      state_d = IDLE;
    end else begin
      case (state_q)
        PREP: state_d = HASH;
        HASH: begin
          cnt_clr = 1'b0;
          cnt_en  = 1'b1;
          if (cnt_last) state_d = WRITE;
        end
        WRITE: begin
          if (pass_q != PW'(PASSES - 1)) begin
            pass_d  = pass_q + PW'(1);
            state_d = PREP;
          end else begin
            state_d = VERIFY;
          end
        end
        VERIFY: begin
`ifdef NONCE_SWEEP_EN
          if (hit || (nonce_q == nonce_last_q)) begin
            done_d  = 1'b1;
            found_d = hit;
            state_d = IDLE;
          end else begin
            nonce_d = nonce_q + NONCE_W'(1);
            pass_d  = '0;
            state_d = PREP;
          end
`else
          done_d  = 1'b1;
          found_d = hit;
          state_d = IDLE;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pass_q  <= '0;
      nonce_q <= '0;
      found_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef NONCE_SWEEP_EN
      nonce_last_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      nonce_q <= nonce_d;
      found_q <= found_d;
      done_q  <= done_d;
`ifdef NONCE_SWEEP_EN
      nonce_last_q <= nonce_last_d;
`endif
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign found    = found_q;
  assign nonce    = nonce_q;
  assign c_init   = (state_q == PREP);
  assign c_read   = (state_q == HASH) && (32'(round) < SCHED_DIRECT);
  assign c_func   = (state_q == HASH) ? group : '0;
  assign c_round  = (state_q == HASH) ? round : '0;
  assign c_pass   = busy ? pass_q : '0;
  assign c_write  = (state_q == WRITE);
  assign c_verify = (state_q == VERIFY);

endmodule

// File: tb/tb_sha_round_sequencer.sv
// Scoreboard bench for sha_round_sequencer: per-cycle strobe model built from
// cycle-offset arithmetic, plus done/found/nonce events predicted at start time.
module tb_sha_round_sequencer;

  localparam int R  = 64;
  localparam int P  = 2;
  localparam int FG = 4;
  localparam int SD = 16;
  localparam int L  = R + 2;
  localparam int T  = P * L + 1;
  localparam logic [31:0] SMALL_NONCE = 32'h0000_00A5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, start, abort, hit;
  logic [31:0] nonce_start, nonce_last;
  logic        busy, done, found, c_init, c_read, c_write, c_verify;
  logic [31:0] nonce;
  logic [1:0]  c_func;
  logic [5:0]  c_round;
  logic [0:0]  c_pass;

  logic        s_start, s_hit;
  logic        s_busy, s_done, s_found, s_c_init, s_c_read, s_c_write, s_c_verify;
  logic [31:0] s_nonce;
  logic [0:0]  s_c_func;
  logic [2:0]  s_c_round;
  logic [0:0]  s_c_pass;

  sha_round_sequencer #(
    .ROUNDS(R), .PASSES(P), .FUNC_GROUPS(FG), .SCHED_DIRECT(SD), .NONCE_W(32)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .nonce_start(nonce_start), .nonce_last(nonce_last), .hit(hit),
    .busy(busy), .done(done), .found(found), .nonce(nonce),
    .c_init(c_init), .c_read(c_read), .c_func(c_func), .c_round(c_round),
    .c_pass(c_pass), .c_write(c_write), .c_verify(c_verify)
  );

  sha_round_sequencer #(
    .ROUNDS(8), .PASSES(1), .FUNC_GROUPS(1), .SCHED_DIRECT(16), .NONCE_W(32)
  ) u_small (
    .clk(clk), .reset_n(reset_n), .start(s_start), .abort(1'b0),
    .nonce_start(SMALL_NONCE), .nonce_last(SMALL_NONCE), .hit(s_hit),
    .busy(s_busy), .done(s_done), .found(s_found), .nonce(s_nonce),
    .c_init(s_c_init), .c_read(s_c_read), .c_func(s_c_func), .c_round(s_c_round),
    .c_pass(s_c_pass), .c_write(s_c_write), .c_verify(s_c_verify)
  );

  typedef struct {
    int          cyc;
    bit          found;
    logic [31:0] nonce;
  } exp_t;

  exp_t sb[$];
  exp_t mon_x;
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;

  bit          m_busy = 1'b0, m_done = 1'b0, m_found = 1'b0;
  int          m_k = 0;
  logic [31:0] m_nonce = '0, m_last = '0;
  bit          hit_en = 1'b0;
  logic [31:0] hit_val = '0;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s at cycle %0d: got %h required %h", name, cyc, act, exp);
  endfunction

  // Attempt-level model: cycle k of an attempt (k=1 is the first cycle after the
  // start edge) decodes to prep/round/write of pass (k-1)/(R+2), verify at k=T.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      m_done = 1'b0;
      if (!reset_n) begin
        m_busy = 1'b0; m_found = 1'b0; m_nonce = '0;
      end else if (!m_busy) begin
        if (start && !abort) begin
          m_busy = 1'b1; m_k = 1; m_nonce = nonce_start; m_last = nonce_last; m_found = 1'b0;
        end
      end else if (abort) begin
        m_busy = 1'b0;
      end else if (m_k == T) begin
`ifdef NONCE_SWEEP_EN
        if (hit || m_nonce == m_last) begin
          m_done = 1'b1; m_found = hit; m_busy = 1'b0;
        end else begin
          m_nonce = m_nonce + 32'd1; m_k = 1;
        end
`else
        m_done = 1'b1; m_found = hit; m_busy = 1'b0;
`endif
      end else begin
        m_k++;
      end
    end
  end

  function automatic logic [47:0] exp_main();
    logic       ini = 1'b0, rd = 1'b0, wr = 1'b0, vf = 1'b0, ps = 1'b0;
    logic [1:0] fn = '0;
    logic [5:0] rn = '0;
    int         pos;
    if (m_busy) begin
      if (m_k <= P * L) begin
        pos = (m_k - 1) % L;
        ps  = 1'((m_k - 1) / L);
        ini = (pos == 0);
        wr  = (pos == R + 1);
        if (pos >= 1 && pos <= R) begin
          rn = 6'(pos - 1);
          rd = (pos - 1) < SD;
          fn = 2'((pos - 1) / (R / FG));
        end
      end else begin
        vf = 1'b1;
        ps = 1'(P - 1);
      end
    end
    return {m_busy, m_done, m_found, m_nonce, ini, rd, fn, rn, ps, wr, vf};
  endfunction

  initial begin
    forever @(negedge clk) hit = hit_en && (m_nonce == hit_val);
  end

  // Monitor: every cycle against the model, and each done pulse against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      chk("outputs", 128'({busy, done, found, nonce, c_init, c_read, c_func, c_round,
                           c_pass, c_write, c_verify}), 128'(exp_main()));
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL done_event at cycle %0d: got done=1 required no done", cyc);
        end else begin
          mon_x = sb.pop_front();
          chk("done_event", 128'({cyc, found, nonce}), 128'({mon_x.cyc, mon_x.found, mon_x.nonce}));
        end
      end else if (sb.size() != 0 && cyc > sb[0].cyc) begin
        mon_x = sb.pop_front();
        checks++;
        $display("FAIL done_missing at cycle %0d: got no done required done at cycle %0d", cyc, mon_x.cyc);
      end
    end
  end

  task automatic launch(input logic [31:0] ns, input logic [31:0] nl, input bit expect_done,
                        input bit hold, output int e);
    exp_t x;
    int   n;
`ifdef NONCE_SWEEP_EN
    logic [31:0] span, d;
`endif
    start = 1'b1; nonce_start = ns; nonce_last = nl;
    e = cyc + 1;
`ifdef NONCE_SWEEP_EN
    span = nl - ns;
    d    = hit_val - ns;
    if (hit_en && d <= span) begin
      n = int'(d) + 1; x.found = 1'b1; x.nonce = hit_val;
    end else begin
      n = int'(span) + 1; x.found = 1'b0; x.nonce = nl;
    end
`else
    n = 1; x.found = hit_en && (hit_val == ns); x.nonce = ns;
`endif
    x.cyc = e + n * T;
    if (expect_done) sb.push_back(x);
    @(negedge clk);
    start = hold;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((m_busy || sb.size() != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) begin
      checks++;
      $display("FAIL wait_idle: got attempt pending after %0d cycles required idle", t);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic small_test();
    int         e, k;
    bit         seen = 1'b0;
    logic       eb, ei, er, ew, ev;
    logic [2:0] erd;
    s_start = 1'b1;
    e = cyc + 1;
    @(negedge clk);
    s_start = 1'b0;
    for (int j = 0; j < 40 && !seen; j++) begin
      k   = cyc - e + 1;
      eb  = (k >= 1 && k <= 11);
      ei  = (k == 1);
      er  = (k >= 2 && k <= 9);
      erd = er ? 3'(k - 2) : 3'd0;
      ew  = (k == 10);
      ev  = (k == 11);
      chk("small_strobes", 128'({s_busy, s_c_init, s_c_read, s_c_round, s_c_write, s_c_verify,
                                 s_c_pass, s_c_func}),
          128'({eb, ei, er, erd, ew, ev, 1'b0, 1'b0}));
      if (s_done === 1'b1) begin
        chk("small_done_cycle", 128'(k), 128'(12));
        chk("small_found_nonce", 128'({s_found, s_nonce}), 128'({1'b0, SMALL_NONCE}));
        seen = 1'b1;
      end
      @(negedge clk);
    end
    if (!seen) begin
      checks++;
      $display("FAIL small_done: got no done in 40 cycles required done in cycle 12");
    end
  endtask

  initial begin
    int          e, kk, mode;
    logic [31:0] ns, nl;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; hit = 1'b0;
    nonce_start = '0; nonce_last = '0; s_start = 1'b0; s_hit = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    small_test();

    hit_en = 1'b1; hit_val = 32'h1234_5678;
    launch(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, e);
    wait_idle();

    hit_en = 1'b0;
    launch(32'hCAFE_0001, 32'hCAFE_0001, 1'b0, 1'b0, e);
    while (cyc < e + 39) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    while (cyc < e + 41) @(negedge clk);
    launch(32'hCAFE_0002, 32'hCAFE_0002, 1'b1, 1'b0, e);
    wait_idle();

    hit_en = 1'b1; hit_val = 32'h0BAD_F00D;
    launch(32'h0BAD_F00D, 32'h0BAD_F00D, 1'b1, 1'b1, e);
    repeat (100) @(negedge clk);
    start = 1'b0;
    wait_idle();

    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);

    launch(32'h7777_0000, 32'h7777_0000, 1'b0, 1'b0, e);
    repeat (20) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

`ifdef NONCE_SWEEP_EN
    hit_en = 1'b1; hit_val = 32'd6;
    launch(32'd5, 32'd7, 1'b1, 1'b0, e);
    wait_idle();
    hit_en = 1'b0;
    launch(32'd5, 32'd7, 1'b1, 1'b0, e);
    wait_idle();
    launch(32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, e);
    wait_idle();
`endif

    for (int i = 0; i < 10; i++) begin
      ns = $urandom;
`ifdef NONCE_SWEEP_EN
      nl = ns + 32'($urandom_range(0, 2));
`else
      nl = $urandom;
`endif
      hit_en  = ($urandom_range(0, 1) == 1);
      hit_val = ns + 32'($urandom_range(0, 2));
      mode    = int'($urandom_range(0, 3));
      launch(ns, nl, mode != 0, 1'b0, e);
      if (mode == 0) begin
        kk = int'($urandom_range(1, T));
        while (cyc < e + kk - 1) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
      end else if (mode == 1) begin
        kk = int'($urandom_range(2, T - 1));
        while (cyc < e + kk - 1) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      wait_idle();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion by time limit required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
